// File: rtl/change_dispenser.sv
// Coin-return payout engine: greedy 100/50/25 Krs payout with per-tube inventory.
// Optional build macro CHANGE_REFILL_EN adds refill/refill_sel ports for restocking tubes in IDLE.
module change_dispenser #(
  parameter int TUBE_W       = 4,
  parameter int INIT_25      = 8,
  parameter int INIT_50      = 4,
  parameter int INIT_100     = 2,
  parameter int EJECT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              change_req,
  input  logic [7:0]        change_amt,
`ifdef CHANGE_REFILL_EN
  input  logic              refill,
  input  logic [1:0]        refill_sel,
`endif
  output logic              change_ack,
  output logic              busy,
  output logic              eject25,
  output logic              eject50,
  output logic              eject100,
  output logic              coin_done,
  output logic              short_err,
  output logic [7:0]        remaining,
  output logic [TUBE_W-1:0] cnt25,
  output logic [TUBE_W-1:0] cnt50,
  output logic [TUBE_W-1:0] cnt100
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_EJECT,
    S_GAP,
    S_DONE,
    S_ERR
  } state_t;

  localparam int EC_W = (EJECT_CYCLES > 1) ? $clog2(EJECT_CYCLES) : 1;
  localparam logic [EC_W-1:0] EC_LAST = EC_W'(EJECT_CYCLES - 1);

  // Tube index 0/1/2 holds 25/50/100 Krs coins.
  function automatic logic [7:0] denom(input logic [1:0] idx);
    case (idx)
      2'd0:    denom = 8'd25;
      2'd1:    denom = 8'd50;
      default: denom = 8'd100;
    endcase
  endfunction

  state_t            state_reg, state_next;
  logic [EC_W-1:0]   ej_cnt_reg, ej_cnt_next;
  logic [1:0]        sel_reg, sel_next;
  logic [7:0]        rem_reg, rem_next;
  logic [TUBE_W-1:0] tube_reg [3];
  logic [TUBE_W-1:0] tube_next [3];

  logic              ack_reg, ack_next;
  logic              busy_reg, busy_next;
  logic [2:0]        ej_reg, ej_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;

  logic [1:0]        pick;
  logic              pick_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      ej_cnt_reg  <= '0;
      sel_reg     <= 2'd0;
      rem_reg     <= 8'd0;
      tube_reg[0] <= TUBE_W'(INIT_25);
      tube_reg[1] <= TUBE_W'(INIT_50);
      tube_reg[2] <= TUBE_W'(INIT_100);
      ack_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      ej_reg      <= 3'b000;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ej_cnt_reg  <= ej_cnt_next;
      sel_reg     <= sel_next;
      rem_reg     <= rem_next;
      tube_reg[0] <= tube_next[0];
      tube_reg[1] <= tube_next[1];
      tube_reg[2] <= tube_next[2];
      ack_reg     <= ack_next;
      busy_reg    <= busy_next;
      ej_reg      <= ej_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    ej_cnt_next  = ej_cnt_reg;
    sel_next     = sel_reg;
    rem_next     = rem_reg;
    tube_next[0] = tube_reg[0];
    tube_next[1] = tube_reg[1];
    tube_next[2] = tube_reg[2];
    ack_next     = 1'b0;
    pick         = 2'd0;
    pick_ok      = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (change_req) begin
          rem_next   = change_amt;
          ack_next   = 1'b1;
          state_next = S_SELECT;
        end
`ifdef CHANGE_REFILL_EN
        else if (refill) begin
          for (int i = 0; i < 3; i++) begin
            if (refill_sel == 2'(i) && tube_reg[i] != '1)
              tube_next[i] = tube_reg[i] + TUBE_W'(1);
          end
        end
`endif
      end

      S_SELECT: begin
        if (rem_reg == 8'd0) begin
          state_next = S_DONE;
        end else if (rem_reg % 8'd25 != 8'd0) begin
          state_next = S_ERR;
        end else begin
          // Largest coin first; a tube is only a candidate while it holds a coin.
          for (int i = 2; i >= 0; i--) begin
            if (!pick_ok && rem_reg >= denom(2'(i)) && tube_reg[i] != '0) begin
              pick_ok = 1'b1;
              pick    = 2'(i);
            end
          end
          if (pick_ok) begin
            sel_next        = pick;
            rem_next        = rem_reg - denom(pick);
            tube_next[pick] = tube_reg[pick] - TUBE_W'(1);
            ej_cnt_next     = '0;
            state_next      = S_EJECT;
          end else begin
            state_next = S_ERR;
          end
        end
      end

      S_EJECT: begin
        if (ej_cnt_reg == EC_LAST)
          state_next = S_GAP;
        else
          ej_cnt_next = ej_cnt_reg + EC_W'(1);
      end

      S_GAP:   state_next = S_SELECT;
      S_DONE:  state_next = S_IDLE;
      S_ERR:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output registers are loaded from the next state so they line up with it.
  always_comb begin
    busy_next = (state_next != S_IDLE);
    done_next = (state_next == S_DONE);
    err_next  = (state_next == S_ERR);
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_eject
    assign ej_next[gi] = (state_next == S_EJECT) && (sel_next == 2'(gi));
  end

  assign change_ack = ack_reg;
  assign busy       = busy_reg;
  assign eject25    = ej_reg[0];
  assign eject50    = ej_reg[1];
  assign eject100   = ej_reg[2];
  assign coin_done  = done_reg;
  assign short_err  = err_reg;
  assign remaining  = rem_reg;
  assign cnt25      = tube_reg[0];
  assign cnt50      = tube_reg[1];
  assign cnt100     = tube_reg[2];

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed table of transactions, reset-during-eject case,
// and random requests checked cycle by cycle against a greedy payout model.
module tb_change_dispenser;
  localparam int TUBE_W = 4;
  localparam int EC     = 2;
  localparam int P      = EC + 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              change_req;
  logic [7:0]        change_amt;
  logic              change_ack, busy, eject25, eject50, eject100, coin_done, short_err;
  logic [7:0]        remaining;
  logic [TUBE_W-1:0] cnt25, cnt50, cnt100;
`ifdef CHANGE_REFILL_EN
  logic              refill = 1'b0;
  logic [1:0]        refill_sel = 2'd3;
`endif

  change_dispenser #(
    .TUBE_W(TUBE_W), .INIT_25(8), .INIT_50(4), .INIT_100(2), .EJECT_CYCLES(EC)
  ) dut (
    .clk(clk), .reset(reset),
    .change_req(change_req), .change_amt(change_amt),
`ifdef CHANGE_REFILL_EN
    .refill(refill), .refill_sel(refill_sel),
`endif
    .change_ack(change_ack), .busy(busy),
    .eject25(eject25), .eject50(eject50), .eject100(eject100),
    .coin_done(coin_done), .short_err(short_err), .remaining(remaining),
    .cnt25(cnt25), .cnt50(cnt50), .cnt100(cnt100)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int m_cnt [3];        // model inventory of 25/50/100 tubes
  int exp_coins [$];    // denominations the model expects, in order

  typedef struct {
    logic [7:0] amt;
    bit         hold;
    bit         ok;
    int         rem;
    int         c25, c50, c100;
  } vec_t;
  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  // Greedy payout, evaluated directly on amounts and inventory.
  task automatic model(input int amt, output bit ok, output int rem);
    int d, idx;
    rem = amt;
    exp_coins.delete();
    ok = 1'b0;
    forever begin
      if (rem == 0) begin ok = 1'b1; return; end
      if (rem % 25 != 0) return;
      d = 0; idx = 0;
      if (rem >= 100 && m_cnt[2] > 0)      begin d = 100; idx = 2; end
      else if (rem >= 50 && m_cnt[1] > 0)  begin d = 50;  idx = 1; end
      else if (rem >= 25 && m_cnt[0] > 0)  begin d = 25;  idx = 0; end
      if (d == 0) return;
      exp_coins.push_back(d);
      rem -= d;
      m_cnt[idx]--;
    end
  endtask

  task automatic check_idle_state(input string tag);
    check({tag, "_outputs"}, {change_ack, busy, eject25, eject50, eject100, coin_done, short_err}, 7'd0);
    check({tag, "_remaining"}, remaining, 0);
    check({tag, "_cnt25"}, cnt25, 8);
    check({tag, "_cnt50"}, cnt50, 4);
    check({tag, "_cnt100"}, cnt100, 2);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; change_req = 1'b0; change_amt = 8'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_cnt[0] = 8; m_cnt[1] = 4; m_cnt[2] = 2;
  endtask

  // One request; compares the full output word every cycle from 1 to E+1.
  task automatic run_txn(input logic [7:0] amt, input bit hold);
    bit ok;
    int rem, n, e_cyc, k, pos;
    logic [6:0] exp_w, got_w;
    logic [2:0] ej;
    model(int'(amt), ok, rem);
    n = exp_coins.size();
    e_cyc = 2 + P * n;
    @(negedge clk);
    change_req = 1'b1;
    change_amt = amt;
    @(posedge clk);
    for (int c = 1; c <= e_cyc + 1; c++) begin
      @(negedge clk);
      if (!hold || c == e_cyc + 1) change_req = 1'b0;
      change_amt = 8'($urandom);
      ej = 3'b000;
      if (c >= 2 && c < e_cyc) begin
        k = (c - 2) / P;
        pos = (c - 2) % P;
        if (pos < EC) begin
          if (exp_coins[k] == 25) ej = 3'b100;
          else if (exp_coins[k] == 50) ej = 3'b010;
          else ej = 3'b001;
        end
      end
      exp_w = {c == 1, c <= e_cyc, ej, (c == e_cyc) && ok, (c == e_cyc) && !ok};
      got_w = {change_ack, busy, eject25, eject50, eject100, coin_done, short_err};
      check($sformatf("wave_amt%0d_cyc%0d", amt, c), 32'(got_w), 32'(exp_w));
    end
    check($sformatf("remaining_amt%0d", amt), remaining, rem);
    check($sformatf("cnt25_amt%0d", amt), cnt25, m_cnt[0]);
    check($sformatf("cnt50_amt%0d", amt), cnt50, m_cnt[1]);
    check($sformatf("cnt100_amt%0d", amt), cnt100, m_cnt[2]);
    $display("txn amt=%0d coins=%0d ok=%0d rem=%0d cnt=%0d/%0d/%0d", amt, n, ok, remaining, cnt25, cnt50, cnt100);
  endtask

  initial begin
    tbl[0] = '{amt: 8'd75,  hold: 1'b0, ok: 1'b1, rem: 0,   c25: 7, c50: 3, c100: 2};
    tbl[1] = '{amt: 8'd175, hold: 1'b1, ok: 1'b1, rem: 0,   c25: 6, c50: 2, c100: 1};
    tbl[2] = '{amt: 8'd100, hold: 1'b0, ok: 1'b1, rem: 0,   c25: 6, c50: 2, c100: 0};
    tbl[3] = '{amt: 8'd100, hold: 1'b1, ok: 1'b1, rem: 0,   c25: 6, c50: 0, c100: 0};
    tbl[4] = '{amt: 8'd0,   hold: 1'b0, ok: 1'b1, rem: 0,   c25: 6, c50: 0, c100: 0};
    tbl[5] = '{amt: 8'd30,  hold: 1'b0, ok: 1'b0, rem: 30,  c25: 6, c50: 0, c100: 0};
    tbl[6] = '{amt: 8'd125, hold: 1'b0, ok: 1'b1, rem: 0,   c25: 1, c50: 0, c100: 0};
    tbl[7] = '{amt: 8'd50,  hold: 1'b1, ok: 1'b0, rem: 25,  c25: 0, c50: 0, c100: 0};
    tbl[8] = '{amt: 8'd25,  hold: 1'b0, ok: 1'b0, rem: 25,  c25: 0, c50: 0, c100: 0};
    tbl[9] = '{amt: 8'd255, hold: 1'b0, ok: 1'b0, rem: 255, c25: 0, c50: 0, c100: 0};

    reset = 1'b1; change_req = 1'b0; change_amt = 8'd0;
    do_reset();
    @(negedge clk);
    check_idle_state("reset");

    for (int i = 0; i < 10; i++) begin
      run_txn(tbl[i].amt, tbl[i].hold);
      check($sformatf("tbl%0d_done", i), 32'(coin_done | short_err), 0);
      check($sformatf("tbl%0d_rem", i), remaining, tbl[i].rem);
      check($sformatf("tbl%0d_c25", i), cnt25, tbl[i].c25);
      check($sformatf("tbl%0d_c50", i), cnt50, tbl[i].c50);
      check($sformatf("tbl%0d_c100", i), cnt100, tbl[i].c100);
    end

    // Reset while eject100 is high: line drops next edge, inventory restored.
    do_reset();
    @(negedge clk);
    change_req = 1'b1; change_amt = 8'd100;
    @(posedge clk);
    @(negedge clk);
    change_req = 1'b0;
    @(negedge clk);
    check("midreset_eject100_high", 32'(eject100), 1);
    check("midreset_cnt100_taken", cnt100, 1);
    reset = 1'b1;
    @(negedge clk);
    check_idle_state("midreset");
    reset = 1'b0;
    m_cnt[0] = 8; m_cnt[1] = 4; m_cnt[2] = 2;

    for (int t = 0; t < 40; t++) begin
      if (t % 8 == 7) do_reset();
      if ($urandom_range(0, 4) == 0)
        run_txn(8'($urandom_range(0, 255)), 1'($urandom));
      else
        run_txn(8'($urandom_range(0, 10) * 25), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
